// File: rtl/game_compositor.sv
// Game display compositor: double-buffered game frame (shadow/active swapped at
// vsync start) resolved per pixel into game cell, border, row flash and overlay
// through a fixed two-stage pipeline.
module game_compositor #(
  parameter int PX_BITS        = 10,
  parameter int PY_BITS        = 10,
  parameter int GAME_X_MIN     = 240,
  parameter int GAME_Y_MIN     = 80,
  parameter int COLS           = 10,
  parameter int ROWS           = 20,
  parameter int CELL_LOG2      = 4,
  parameter int BORDER_PAD     = 1,
  parameter int BORDER_THICK   = 10,
  parameter int FRAME_CNT_BITS = 8,
  parameter int BLINK_BIT      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      v_sync,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  input  logic [COLS*ROWS-1:0]      frame_data,
  input  logic [ROWS-1:0]           flash_rows,
  input  logic [PX_BITS-1:0]        pixel_x_next,
  input  logic [PY_BITS-1:0]        pixel_y_next,
  input  logic                      overlay_pixel,
  output logic                      pixel_value,
  output logic [FRAME_CNT_BITS-1:0] frame_count
);

  localparam int NumCells = COLS * ROWS;
  localparam int ColW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RowW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IdxW     = (NumCells > 1) ? $clog2(NumCells) : 1;

  // Exclusive upper bounds of the game area
  localparam int GxMax = GAME_X_MIN + (COLS << CELL_LOG2);
  localparam int GyMax = GAME_Y_MIN + (ROWS << CELL_LOG2);

  // Outer edge of the border ring and the inner (pad) keep-out box
  localparam int OxLo = GAME_X_MIN - BORDER_PAD - BORDER_THICK;
  localparam int OxHi = GxMax + BORDER_PAD + BORDER_THICK;
  localparam int OyLo = GAME_Y_MIN - BORDER_PAD - BORDER_THICK;
  localparam int OyHi = GyMax + BORDER_PAD + BORDER_THICK;
  localparam int IxLo = GAME_X_MIN - BORDER_PAD;
  localparam int IxHi = GxMax + BORDER_PAD;
  localparam int IyLo = GAME_Y_MIN - BORDER_PAD;
  localparam int IyHi = GyMax + BORDER_PAD;

  localparam logic [FRAME_CNT_BITS-1:0] CntOne = 1;

  // Frame buffers and handshake state
  logic [NumCells-1:0]       shadow_cells_q, shadow_cells_d;
  logic [ROWS-1:0]           shadow_flash_q, shadow_flash_d;
  logic [NumCells-1:0]       active_cells_q, active_cells_d;
  logic [ROWS-1:0]           active_flash_q, active_flash_d;
  logic                      pending_q, pending_d;
  logic                      v_sync_q, v_sync_d;
  logic [FRAME_CNT_BITS-1:0] frame_count_q, frame_count_d;

  // Pipeline registers
  logic            in_game_q, in_game_d;
  logic            in_border_q, in_border_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            overlay_q, overlay_d;
  logic            pixel_value_q, pixel_value_d;

  logic            vs_start;
  logic            xfer;

  // Handshake, vsync edge detect, buffer promotion and frame counter
  always_comb begin
    vs_start       = !v_sync && v_sync_q;
    frame_ready    = !pending_q && !vs_start && !reset;
    xfer           = frame_valid && frame_ready;
    shadow_cells_d = shadow_cells_q;
    shadow_flash_d = shadow_flash_q;
    active_cells_d = active_cells_q;
    active_flash_d = active_flash_q;
    pending_d      = pending_q;
    frame_count_d  = frame_count_q;
    v_sync_d       = v_sync;
    if (vs_start) begin
      frame_count_d = frame_count_q + CntOne;
      if (pending_q) begin
        active_cells_d = shadow_cells_q;
        active_flash_d = shadow_flash_q;
        pending_d      = 1'b0;
      end
    end
    // frame_ready excludes vs_start, so a transfer never coincides with a swap
    if (xfer) begin
      shadow_cells_d = frame_data;
      shadow_flash_d = flash_rows;
      pending_d      = 1'b1;
    end
  end

  // Stage 1: region classification and cell addressing
  always_comb begin
    int px;
    int py;
    logic in_outer;
    logic in_inner;
    px          = int'(pixel_x_next);
    py          = int'(pixel_y_next);
    in_game_d   = (px >= GAME_X_MIN) && (px < GxMax) && (py >= GAME_Y_MIN) && (py < GyMax);
    in_outer    = (px >= OxLo) && (px < OxHi) && (py >= OyLo) && (py < OyHi);
    in_inner    = (px >= IxLo) && (px < IxHi) && (py >= IyLo) && (py < IyHi);
    in_border_d = in_outer && !in_inner;
    overlay_d   = overlay_pixel;
    // Indices stay 0 outside the game area so the buffer never sees a wild index
    col_d       = '0;
    row_d       = '0;
    if (in_game_d) begin
      col_d = ColW'((px - GAME_X_MIN) >>> CELL_LOG2);
      row_d = RowW'((py - GAME_Y_MIN) >>> CELL_LOG2);
    end
  end

  // Stage 2: buffer lookup, blink and final composite
  always_comb begin
    logic [IdxW-1:0] cell_idx;
    logic            blink;
    logic            lit;
    cell_idx      = IdxW'(int'(row_q) * COLS + int'(col_q));
    blink         = frame_count_q[BLINK_BIT];
    lit           = active_cells_q[cell_idx] && !(active_flash_q[row_q] && blink);
    pixel_value_d = (in_game_q && lit) || in_border_q || overlay_q;
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_cells_q <= '0;
      shadow_flash_q <= '0;
      active_cells_q <= '0;
      active_flash_q <= '0;
      pending_q      <= 1'b0;
      v_sync_q       <= 1'b1;
      frame_count_q  <= '0;
      in_game_q      <= 1'b0;
      in_border_q    <= 1'b0;
      col_q          <= '0;
      row_q          <= '0;
      overlay_q      <= 1'b0;
      pixel_value_q  <= 1'b0;
    end else begin
      shadow_cells_q <= shadow_cells_d;
      shadow_flash_q <= shadow_flash_d;
      active_cells_q <= active_cells_d;
      active_flash_q <= active_flash_d;
      pending_q      <= pending_d;
      v_sync_q       <= v_sync_d;
      frame_count_q  <= frame_count_d;
      in_game_q      <= in_game_d;
      in_border_q    <= in_border_d;
      col_q          <= col_d;
      row_q          <= row_d;
      overlay_q      <= overlay_d;
      pixel_value_q  <= pixel_value_d;
    end
  end

  assign pixel_value = pixel_value_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_game_compositor.sv
// Self-checking bench for game_compositor: directed scenarios plus a random
// phase, all compared every cycle against a behavioural display model.
module tb_game_compositor;

  localparam int GXMIN = 240;
  localparam int GYMIN = 80;
  localparam int NCOL  = 10;
  localparam int NROW  = 20;
  localparam int CELL  = 16;
  localparam int PAD   = 1;
  localparam int THK   = 10;
  localparam int BLINK = 4;
  localparam int NC    = NCOL * NROW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          v_sync = 1'b1;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [NC-1:0] frame_data = '0;
  logic [NROW-1:0] flash_rows = '0;
  logic [9:0]    pixel_x_next = '0;
  logic [9:0]    pixel_y_next = '0;
  logic          overlay_pixel = 1'b0;
  logic          pixel_value;
  logic [7:0]    frame_count;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the display
  logic            m_vsq = 1'b1;
  logic            m_pend = 1'b0;
  logic [7:0]      m_count = '0;
  logic [NC-1:0]   m_shadow = '0;
  logic [NROW-1:0] m_sflash = '0;
  logic [NC-1:0]   m_active = '0;
  logic [NROW-1:0] m_aflash = '0;
  logic            m_s1_v = 1'b0;
  int              m_s1_x = 0;
  int              m_s1_y = 0;
  logic            m_s1_ov = 1'b0;
  logic            m_pix = 1'b0;

  game_compositor #(
    .PX_BITS(10), .PY_BITS(10), .GAME_X_MIN(GXMIN), .GAME_Y_MIN(GYMIN), .COLS(NCOL),
    .ROWS(NROW), .CELL_LOG2(4), .BORDER_PAD(PAD), .BORDER_THICK(THK), .FRAME_CNT_BITS(8),
    .BLINK_BIT(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .v_sync(v_sync), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .flash_rows(flash_rows),
    .pixel_x_next(pixel_x_next), .pixel_y_next(pixel_y_next), .overlay_pixel(overlay_pixel),
    .pixel_value(pixel_value), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // What the screen should show at (x,y) given the displayed frame and counter
  function automatic logic ref_pix(input int x, input int y, input logic ov);
    int   gx1, gy1, c, r;
    logic in_game, outer, inner, lit;
    logic [NC-1:0]   cells;
    logic [NROW-1:0] fl;
    gx1     = GXMIN + NCOL * CELL;
    gy1     = GYMIN + NROW * CELL;
    in_game = x >= GXMIN && x < gx1 && y >= GYMIN && y < gy1;
    outer   = x >= GXMIN - PAD - THK && x < gx1 + PAD + THK &&
              y >= GYMIN - PAD - THK && y < gy1 + PAD + THK;
    inner   = x >= GXMIN - PAD && x < gx1 + PAD && y >= GYMIN - PAD && y < gy1 + PAD;
    lit     = 1'b0;
    if (in_game) begin
      c     = (x - GXMIN) / CELL;
      r     = (y - GYMIN) / CELL;
      cells = m_active >> (r * NCOL + c);
      fl    = m_aflash >> r;
      lit   = cells[0] && !(fl[0] && m_count[BLINK]);
    end
    return (in_game && lit) || (outer && !inner) || ov;
  endfunction

  // One clock: check ready mid-cycle, advance the model, check registered outputs
  task automatic step();
    logic vs, rdy, newpix, fv, vsin, ov;
    logic [NC-1:0]   fd;
    logic [NROW-1:0] fr;
    int cx, cy;
    @(negedge clk);
    vs  = !v_sync && m_vsq;
    rdy = !m_pend && !vs && !reset;
    chk("frame_ready", {31'b0, frame_ready}, {31'b0, rdy});
    newpix = 1'b0;
    if (!reset && m_s1_v) newpix = ref_pix(m_s1_x, m_s1_y, m_s1_ov);
    fv = frame_valid; fd = frame_data; fr = flash_rows; vsin = v_sync;
    cx = int'(pixel_x_next); cy = int'(pixel_y_next); ov = overlay_pixel;
    @(posedge clk);
    #1;
    if (reset) begin
      m_vsq = 1'b1; m_pend = 1'b0; m_count = '0; m_shadow = '0; m_sflash = '0;
      m_active = '0; m_aflash = '0; m_s1_v = 1'b0;
    end else begin
      if (vs) begin
        m_count++;
        if (m_pend) begin
          m_active = m_shadow; m_aflash = m_sflash; m_pend = 1'b0;
        end
      end
      if (fv && rdy) begin
        m_shadow = fd; m_sflash = fr; m_pend = 1'b1;
      end
      m_vsq = vsin; m_s1_v = 1'b1; m_s1_x = cx; m_s1_y = cy; m_s1_ov = ov;
    end
    m_pix = newpix;
    chk("pixel_value", {31'b0, pixel_value}, {31'b0, m_pix});
    chk("frame_count", {24'b0, frame_count}, {24'b0, m_count});
  endtask

  task automatic px(input int x, input int y, input logic ov);
    pixel_x_next  = 10'(x);
    pixel_y_next  = 10'(y);
    overlay_pixel = ov;
    step();
  endtask

  task automatic vsync_pulse();
    v_sync = 1'b0; step();
    v_sync = 1'b1; step();
  endtask

  task automatic do_reset();
    reset = 1'b1; step();
    reset = 1'b0;
  endtask

  task automatic offer(input logic [NC-1:0] d, input logic [NROW-1:0] f);
    frame_data = d; flash_rows = f; frame_valid = 1'b1; step();
    frame_valid = 1'b0;
  endtask

  function automatic logic [NC-1:0] rand_frame();
    logic [223:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[NC-1:0];
  endfunction

  initial begin
    logic [31:0] r;
    logic [NC-1:0] one_bit;
    int bx [7];
    bx = '{228, 229, 238, 239, 400, 410, 411};

    // Reset and handshake/swap
    do_reset();
    step();
    one_bit = '0; one_bit[0] = 1'b1;
    offer(one_bit, '0);
    for (int i = 0; i < 3; i++) px(240, 80, 0);
    vsync_pulse();
    px(240, 80, 0); px(255, 95, 0); px(256, 80, 0); px(240, 80, 0); px(240, 80, 0);

    // Latency and addressing with the last cell lit
    one_bit = '0; one_bit[NC-1] = 1'b1;
    offer(one_bit, '0);
    vsync_pulse();
    px(399, 399, 0); px(398, 398, 0); px(239, 80, 0); px(0, 0, 0); px(0, 0, 0);

    // Border geometry
    foreach (bx[i]) px(bx[i], 200, 0);
    px(300, 69, 0); px(300, 68, 0); px(300, 400, 0); px(300, 410, 0); px(300, 411, 0);
    px(0, 0, 1); px(0, 0, 0); px(0, 0, 0);

    // Row flash: row 0 flashed, row 1 steady, across two blink periods
    do_reset();
    offer({{(NC - 20){1'b0}}, 20'hFFFFF}, 20'h00001);
    vsync_pulse();
    for (int f = 0; f < 36; f++) begin
      px(240, 80, 0); px(250, 96, 0);
      vsync_pulse();
    end

    // Back-pressure: A pending, B held until after the swap
    do_reset();
    frame_data = rand_frame(); flash_rows = '0; frame_valid = 1'b1; step();
    frame_data = rand_frame();
    for (int i = 0; i < 4; i++) px(240 + 16 * i, 80 + 16 * i, 0);
    vsync_pulse();
    frame_valid = 1'b0;
    for (int i = 0; i < 4; i++) px(240 + 16 * i, 80 + 16 * i, 0);
    vsync_pulse();
    for (int i = 0; i < 4; i++) px(240 + 16 * i, 80 + 16 * i, 0);
    // Offer raised on the vs_start cycle itself
    frame_data = rand_frame(); frame_valid = 1'b1; v_sync = 1'b0; step();
    v_sync = 1'b1; step(); frame_valid = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 4; i++) px(250 + 16 * i, 90, 0);

    // Reset mid-frame with a pending frame and an active stream
    offer({NC{1'b1}}, '0);
    px(240, 80, 0); px(300, 200, 0);
    reset = 1'b1; px(229, 200, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) px(229 + i, 200, 0);
    for (int i = 0; i < 3; i++) px(300, 200, 0);
    vsync_pulse();
    for (int i = 0; i < 3; i++) px(300, 200, 0);

    // Frame counter wrap
    do_reset();
    for (int f = 0; f < 260; f++) vsync_pulse();

    // Random traffic
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      r = $urandom();
      reset         = (r[7:0] == 8'd0);
      v_sync        = (r[10:8] != 3'd0);
      frame_valid   = r[11];
      overlay_pixel = (r[14:12] == 3'd0);
      if (r[15]) frame_data = rand_frame();
      flash_rows    = 20'($urandom());
      pixel_x_next  = 10'($urandom_range(220, 420));
      pixel_y_next  = 10'($urandom_range(60, 420));
      step();
    end
    reset = 1'b0; v_sync = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_compositor.md
# game_compositor

Parametrised VGA pixel compositor for the game display. It sits between the game-state producer and the VGA timing generator. Game frames are accepted over a valid/ready handshake into a shadow buffer and promoted to the active buffer at the start of each vertical sync, which gives tear-free updates. Each requested pixel is resolved to game cell, border, row-flash or overlay through a fixed 2-cycle pipeline.

## Interface
Parameters:
- PX_BITS, 10, width of pixel x coordinate
- PY_BITS, 10, width of pixel y coordinate
- GAME_X_MIN, 240, left edge of game area (pixels)
- GAME_Y_MIN, 80, top edge of game area (pixels)
- COLS, 10, game columns
- ROWS, 20, game rows
- CELL_LOG2, 4, log2 of cell edge in pixels (16x16 cells)
- BORDER_PAD, 1, gap between game area and border inner edge
- BORDER_THICK, 10, border ring thickness
- FRAME_CNT_BITS, 8, frame counter width
- BLINK_BIT, 4, frame_count bit used as blink phase (must be < FRAME_CNT_BITS)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- v_sync  in  1  VGA vertical sync, active-low pulse
- frame_valid  in  1  producer offers a frame
- frame_ready  out  1  shadow buffer free
- frame_data  in  COLS*ROWS  cell bits; bit index = row*COLS + col
- flash_rows  in  ROWS  rows to blink, travels with frame_data
- pixel_x_next  in  PX_BITS  requested pixel x
- pixel_y_next  in  PY_BITS  requested pixel y
- overlay_pixel  in  1  external overlay (telemetry) bit, aligned with the coordinates
- pixel_value  out  1  composited pixel, 2 cycles after its coordinates
- frame_count  out  FRAME_CNT_BITS  vsync-start count, wraps

## Operation
- Derived bounds: GX_MAX = GAME_X_MIN + (COLS<<CELL_LOG2) and GY_MAX = GAME_Y_MIN + (ROWS<<CELL_LOG2), both exclusive.
- Game region: GAME_X_MIN ≤ x < GX_MAX and GAME_Y_MIN ≤ y < GY_MAX.
- Border region: inside [MIN-PAD-THICK, MAX+PAD+THICK) on both axes and outside [MIN-PAD, MAX+PAD) on either axis.
- Cell addressing: col = (x-GAME_X_MIN)>>CELL_LOG2 and row = (y-GAME_Y_MIN)>>CELL_LOG2.
  - The lookup is used only when the pixel is in the game region.
  - No out-of-range index may reach the buffer; outside-region indices are forced to 0.
- Shadow handshake:
  - Transfer occurs when frame_valid && frame_ready. On transfer, frame_data and flash_rows go to the shadow buffer and pending=1.
  - frame_ready = !pending && !vs_start && !reset.
- vs_start: one-cycle pulse when v_sync is 0 and v_sync_q (registered v_sync) is 1. On vs_start:
  - frame_count increments.
  - If pending, shadow is copied to active (cells and flash mask) and pending clears.
  - If not pending, active is unchanged and the last frame is redisplayed.
- Blink: blink = frame_count[BLINK_BIT]. A cell is lit iff active_cell && !(active_flash[row] && blink).
- Composite: pixel_value = (in_game && lit) || in_border || overlay_pixel.
- Regions are disjoint by construction when BORDER_PAD ≥ 0.

## Timing
- Stage 1 (cycle N+1) registers:
  - in_game, in_border, col, row
  - overlay_pixel
- Stage 2 (cycle N+2) registers pixel_value from the active buffer and the current blink.
- Latency: exactly 2 cycles; throughput 1 pixel/cycle; no stalls.
- Swap timing: the swap and the counter increment take effect at the end of the vs_start cycle. Pixels entering stage 2 from the following cycle onward see the new frame.
- Simultaneous frame_valid and vs_start: no transfer that cycle (frame_ready low). The offer is accepted the next cycle if the producer holds it.
- Back-pressure: while pending, frame_ready=0. A producer holding frame_valid waits until the next vs_start, and is accepted in the cycle after it.
- Reset values:
  - pending=0
  - shadow and active buffers all 0
  - frame_count=0
  - v_sync_q=1, so there is no false vs_start at release
  - pipeline registers 0 and pixel_value=0
  - frame_ready=0 during reset, 1 in the first cycle after release
- Reset mid-operation: a pending frame is discarded and the display goes blank apart from the border.
  - Pipelined pixels in flight are flushed to 0.
  - The border reappears 2 cycles after the first post-reset coordinate.
- frame_count wraps from 2^FRAME_CNT_BITS-1 to 0 with no other effect.

## Test plan
- Handshake and swap: after reset, frame_valid=1 with frame_data bit 0 set.
  - frame_ready drops the following cycle.
  - (240,80) stays 0 until vs_start. After vs_start, (240,80) and (255,95) give 1 and (256,80) gives 0.
- Latency and addressing: stream (399,399), (398,398), (239,80) back to back with bit 199 active.
  - pixel_value is 1,1,0 on cycles N+2..N+4.
- Border geometry with defaults, y=200:
  - x=228 gives 0; x=229 gives 1; x=238 gives 1; x=239 gives 0 (pad); x=400 gives 0; x=410 gives 1; x=411 gives 0.
  - Check the y edges the same way: y=69 gives 1 and y=68 gives 0.
- Row flash: active frame with row 0 full and flash_rows[0]=1, stepping vs_start pulses.
  - (240,80) reads 1 for frame_count 0–15 and 0 for 16–31.
  - A non-flashed full row stays 1 throughout.
- Back-pressure collision: frame A pending, frame B offered continuously.
  - B is not accepted until the cycle after vs_start.
  - A displays first; B displays after the second vs_start.
  - Asserting frame_valid exactly on the vs_start cycle gives no transfer that cycle.
- Reset mid-frame: pending frame present and stream active, then reset for 1 cycle.
  - pixel_value=0 for 2 cycles after release.
  - Then border only; frame_count=0; frame_ready=1; the old shadow is never displayed.
